io_arbiter_b3: RTL
==================

Name: io_arbiter_b3

Overview:
- Shares the single basic on-board I/O register bus (4-bit address, 8-bit data, re/we strobes) between two requesters.
- m0 is the CPU I/O port; m1 is a secondary master, such as a debug/loader engine.
- Sequences each access as a fixed 3-state transaction and returns registered read data with a one-cycle ack pulse.
- Sits between the requesters and the basic I/O block; the basic I/O block's read path is combinational on addr/re.

Parameters:
- AW, 4, I/O register address width
- DW, 8, data width
- RR, 1, 1 = round-robin priority; 0 = fixed priority, m0 always wins

Ports:
- clk  in  1  100MHz system clock
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  m0 transaction request; held with its fields until m0_ack
- m0_we  in  1  1 = write, 0 = read
- m0_addr  in  AW  m0 register address
- m0_wdata  in  DW  m0 write data
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  DW  read data, valid while m0_ack is high and held until the next m0 read completes
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  same widths and meaning as the m0 ports, for m1
- io_addr  out  AW  address to the I/O block
- io_re  out  1  read strobe
- io_we  out  1  write strobe
- io_wdata  out  DW  data to the I/O block
- io_rdata  in  DW  data from the I/O block (combinational)
- owner  out  1  index of the master that currently holds the bus or was last granted

Behaviour:
- Reset values: state=IDLE, io_re=0, io_we=0, io_addr=0, io_wdata=0, m0_ack=0, m1_ack=0, m0_rdata=0, m1_rdata=0, owner=0, last=1 (so m0 is preferred after reset).
- All outputs are registered.
- FSM states:
  - IDLE: if any req is high, pick a winner, register owner, and load io_addr/io_wdata from the winner. Set io_we=winner.we and io_re=~winner.we. Go to ACCESS.
  - ACCESS: strobes are high for exactly this one cycle. At its closing edge, capture io_rdata into the owner's rdata register (reads only; writes leave rdata unchanged). Deassert strobes, pulse the owner's ack, go to DONE.
  - DONE: ack is high for this one cycle. Set last=owner, go to IDLE.
- Latency: req sampled at edge N -> strobes high in cycle N+1 -> ack high in cycle N+2. The minimum period for back-to-back transactions from one master is 3 cycles.
- Arbitration with RR=1 and both reqs high in IDLE: grant ~last.
- Arbitration with RR=0: m0 wins whenever its req is high.
- A single request is always granted.
- A req still high in the IDLE cycle after ack counts as a new transaction. Requesters drop req in the cycle after ack unless they want another access.
- A req that falls before ack (protocol violation): the transaction still completes and the ack is still issued, using the fields latched in IDLE.
- The loser's req stays pending and is served next. There is no starvation with RR=1; m1 may starve with RR=0.
- Reset mid-transaction: the FSM returns to IDLE on the next edge, strobes drop, and no ack is issued. The aborted write may or may not have landed; the requester must reissue it.
- Only one strobe is active in any cycle; io_re and io_we are never both 1.
- io_addr and io_wdata hold their values outside ACCESS, so there are no spurious strobes.

Optional Feature:
- Macro: IO_ARB_LOCK_EN.
- Defined:
  - Adds input ports m0_lock and m1_lock.
  - A master that completes a transaction with its lock=1 keeps ownership. In IDLE, only its req is considered while its lock stays high; the other master waits.
  - Lock release takes effect at the next IDLE.
  - Reset clears ownership to m0.
- Undefined:
  - The lock ports do not exist.
  - Arbitration follows only RR and last.

Decomposition:
- Package io_arb_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_DONE=2'd2
  - master index constants M0=1'b0, M1=1'b1
  - default widths IO_AW=4, IO_DW=8
- Sub-module io_arb_pick:
  - purely combinational winner selection from req0, req1, last, RR, and the lock inputs when IO_ARB_LOCK_EN is defined
  - instantiated once, in the IDLE decision

Test Plan:
- Write from m0 only: m0 writes addr=4'h4, wdata=8'hA5 -> io_we=1 with io_addr=4, io_wdata=A5 for exactly 1 cycle -> m0_ack in the following cycle. The I/O block then reads back LED LSB = A5.
- Read from m1 only: m1 reads addr=4'h0 with io_rdata driven to 8'h3C -> io_re high 1 cycle -> m1_ack with m1_rdata=3C, 2 cycles after req is sampled.
- Round-robin contention: both reqs high continuously with RR=1 after reset -> grants go m0, m1, m0, m1, with acks 3 cycles apart and never both acks in the same cycle.
- Fixed priority: both reqs high with RR=0 -> m0 is served every transaction and m1_ack stays 0; dropping m0_req -> m1 is served next.
- Reset during ACCESS: assert reset in the strobe cycle -> next cycle state is IDLE, strobes=0, no ack, owner=0.
- Lock (IO_ARB_LOCK_EN): m1_lock=1 with both reqs high -> three consecutive m1 transactions; deassert m1_lock -> the next grant goes to m0.

Source files
------------

// File: rtl/io_arb_pkg.sv
// Shared constants and state type for the two-master I/O register bus arbiter.
package io_arb_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int IO_AW = 4;
  localparam int IO_DW = 8;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ACCESS = ST_ACCESS,
    DONE   = ST_DONE
  } state_t;
endpackage

// File: rtl/io_arb_pick.sv
// Combinational winner selection for the arbiter IDLE decision.
// With IO_ARB_LOCK_EN defined, a held lock restricts the choice to the holder.
module io_arb_pick
  import io_arb_pkg::*;
#(
  parameter int RR = 1
) (
  input  logic req0,
  input  logic req1,
  input  logic last,
`ifdef IO_ARB_LOCK_EN
  input  logic hold,
  input  logic holder,
`endif
  output logic grant,
  output logic win
);

  always_comb begin
    grant = req0 | req1;
    if (req0 && req1) win = (RR != 0) ? ~last : M0;
    else              win = req1 ? M1 : M0;
`ifdef IO_ARB_LOCK_EN
    // While locked, the other master is ignored even if the holder is idle.
    if (hold) begin
      win   = holder;
      grant = holder ? req1 : req0;
    end
`endif
  end

endmodule

// File: rtl/io_arbiter_b3.sv
// Two-master arbiter for the basic I/O register bus: IDLE -> ACCESS -> DONE per access.
// Optional bus locking is compiled in with IO_ARB_LOCK_EN.
module io_arbiter_b3
  import io_arb_pkg::*;
#(
  parameter int AW = IO_AW,
  parameter int DW = IO_DW,
  parameter int RR = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
`ifdef IO_ARB_LOCK_EN
  input  logic          m0_lock,
  input  logic          m1_lock,
`endif
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] io_addr,
  output logic          io_re,
  output logic          io_we,
  output logic [DW-1:0] io_wdata,
  input  logic [DW-1:0] io_rdata,
  output logic          owner,
  output logic [1:0]    fsm_state
);

  // Handshake: a master raises req with we/addr/wdata stable and holds them until
  // its one-cycle ack; rdata is valid with ack and held until the next read ack.
  state_t state;
  logic   last;
  logic   grant;
  logic   win;
  logic   win_we;

  assign win_we    = win ? m1_we : m0_we;
  assign fsm_state = state;

`ifdef IO_ARB_LOCK_EN
  logic locked;
  logic hold;
  assign hold = locked & (owner ? m1_lock : m0_lock);
`endif

  io_arb_pick #(.RR(RR)) u_pick (
    .req0   (m0_req),
    .req1   (m1_req),
    .last   (last),
`ifdef IO_ARB_LOCK_EN
    .hold   (hold),
    .holder (owner),
`endif
    .grant  (grant),
    .win    (win)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      io_re    <= 1'b0;
      io_we    <= 1'b0;
      io_addr  <= '0;
      io_wdata <= '0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      owner    <= M0;
      last     <= M1;
`ifdef IO_ARB_LOCK_EN
      locked   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            owner    <= win;
            io_addr  <= win ? m1_addr : m0_addr;
            io_wdata <= win ? m1_wdata : m0_wdata;
            io_we    <= win_we;
            io_re    <= ~win_we;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          io_re <= 1'b0;
          io_we <= 1'b0;
          if (io_re) begin
            if (owner) m1_rdata <= io_rdata;
            else       m0_rdata <= io_rdata;
          end
          if (owner) m1_ack <= 1'b1;
          else       m0_ack <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          last   <= owner;
`ifdef IO_ARB_LOCK_EN
          locked <= owner ? m1_lock : m0_lock;
`endif
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
